// File: rtl/line_clear.sv
// line_clear: removes full rows from a landed board, compacts the rest
// toward the bottom, and keeps a saturating score of lines_cleared^2.
// Ports:
//   clka          clock, all state updates on its rising edge
//   restart       synchronous active-high reset, aborts any operation
//   start         capture board_in and begin an operation
//   board_in      landed board, row r = bits [COLS*r +: COLS], row 0 top
//   board_out     compacted board, held between operations
//   lines_cleared full rows removed by the last operation
//   score         running saturating score
//   busy          high while an operation is in flight
//   done          one-cycle pulse when results are valid
module line_clear #(
    parameter int ROWS    = 8,
    parameter int COLS    = 4,
    parameter int SCORE_W = 16
) (
    input  logic                      clka,
    input  logic                      restart,
    input  logic                      start,
    input  logic [ROWS*COLS-1:0]      board_in,
    output logic [ROWS*COLS-1:0]      board_out,
    output logic [$clog2(ROWS+1)-1:0] lines_cleared,
    output logic [SCORE_W-1:0]        score,
    output logic                      busy,
    output logic                      done
);

    localparam int W     = ROWS * COLS;
    localparam int LW    = $clog2(ROWS + 1);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SQ_W  = 2 * LW;
    localparam int SUM_W = ((SCORE_W > SQ_W) ? SCORE_W : SQ_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FILL,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [W-1:0]    scratch_q;
    logic [W-1:0]    result_q;
    logic [RW-1:0]   rd_q;
    logic [RW-1:0]   wr_q;
    logic [LW-1:0]   clr_q;

    logic [COLS-1:0] scan_row;
    logic            row_full;
    logic [W-1:0]    fill_board;
    logic [SQ_W-1:0] sq;
    logic [SUM_W-1:0] sum;
    logic [SCORE_W-1:0] score_nxt;
    logic            capture;

    // DONE hands straight back to capture so a held start sustains
    // one board every ROWS+2 cycles.
    assign capture = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (rd_q == '0) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = start ? SCAN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scan_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (rd_q == RW'(r)) begin
                scan_row = scratch_q[r*COLS +: COLS];
            end
        end
    end

    assign row_full = &scan_row;

    // Rows above the compacted stack (one per cleared row) read as empty.
    always_comb begin
        fill_board = result_q;
        for (int r = 0; r < ROWS; r++) begin
            if (LW'(r) < clr_q) begin
                fill_board[r*COLS +: COLS] = '0;
            end
        end
    end

    // Square and sum are kept wider than the score so the increment
    // itself never truncates before saturation is applied.
    assign sq  = SQ_W'(clr_q) * SQ_W'(clr_q);
    assign sum = SUM_W'(score) + SUM_W'(sq);

    always_comb begin
        if (|sum[SUM_W-1:SCORE_W]) begin
            score_nxt = '1;
        end else begin
            score_nxt = sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            scratch_q     <= '0;
            result_q      <= '0;
            rd_q          <= '0;
            wr_q          <= '0;
            clr_q         <= '0;
            board_out     <= '0;
            lines_cleared <= '0;
            score         <= '0;
        end else begin
            if (capture) begin
                scratch_q <= board_in;
                result_q  <= '0;
                rd_q      <= RW'(ROWS - 1);
                wr_q      <= RW'(ROWS - 1);
                clr_q     <= '0;
            end else if (state_q == SCAN) begin
                if (row_full) begin
                    clr_q <= clr_q + 1'b1;
                end else begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (wr_q == RW'(r)) begin
                            result_q[r*COLS +: COLS] <= scan_row;
                        end
                    end
                    wr_q <= wr_q - 1'b1;
                end
                rd_q <= rd_q - 1'b1;
            end else if (state_q == FILL) begin
                board_out     <= fill_board;
                lines_cleared <= clr_q;
                score         <= score_nxt;
            end
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// tb_line_clear: randomized and directed boards checked against a
// queue-based row-compaction model, with a narrow-score second instance.
module tb_line_clear;

    localparam int ROWS = 8;
    localparam int COLS = 4;
    localparam int W    = ROWS * COLS;

    logic         clka = 1'b0;
    logic         restart = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] board_in = '0;

    logic [W-1:0] board_out, board_out_s;
    logic [3:0]   lines_cleared, lines_cleared_s;
    logic [15:0]  score;
    logic [5:0]   score_s;
    logic         busy, busy_s, done, done_s;

    int checks = 0;
    int failures = 0;
    int exp_score = 0;
    int exp_score_s = 0;

    always #5 clka = ~clka;

    line_clear #(.ROWS(8), .COLS(4), .SCORE_W(16)) u_dut (
        .clka(clka), .restart(restart), .start(start),
        .board_in(board_in), .board_out(board_out),
        .lines_cleared(lines_cleared), .score(score),
        .busy(busy), .done(done)
    );

    line_clear #(.ROWS(8), .COLS(4), .SCORE_W(6)) u_sat (
        .clka(clka), .restart(restart), .start(start),
        .board_in(board_in), .board_out(board_out_s),
        .lines_cleared(lines_cleared_s), .score(score_s),
        .busy(busy_s), .done(done_s)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Keep non-full rows bottom-first, then restack them from the bottom.
    function automatic logic [W-1:0] model(input logic [W-1:0] b,
                                           output int n);
        logic [COLS-1:0] kept[$];
        logic [W-1:0] o;
        n = 0;
        o = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (b[r*COLS +: COLS] == '1) n++;
            else kept.push_back(b[r*COLS +: COLS]);
        end
        foreach (kept[i]) o[(ROWS-1-i)*COLS +: COLS] = kept[i];
        return o;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_board"}, 64'(board_out), 64'd0);
        check({tag, "_lines"}, 64'(lines_cleared), 64'd0);
        check({tag, "_score"}, 64'(score), 64'd0);
        check({tag, "_score_s"}, 64'(score_s), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // extra_at / rst_at: edge offset from the capture edge at which a
    // second start or a restart is sampled; -1 disables.
    task automatic run_board(input logic [W-1:0] b, input int extra_at,
                             input int rst_at);
        logic [W-1:0] exp_b;
        int n;
        int dones = 0;
        int done_k = -1;
        logic [W-1:0] got_b = '0;
        logic [3:0]   got_l = '0;
        logic [15:0]  got_s = '0;
        logic [5:0]   got_ss = '0;
        exp_b = model(b, n);
        @(negedge clka);
        board_in = b;
        start = 1'b1;
        @(posedge clka);
        #1;
        start = 1'b0;
        board_in = $urandom;
        for (int k = 1; k <= ROWS + 2; k++) begin
            @(posedge clka);
            @(negedge clka);
            if (k == 1) check("busy_scan", 64'(busy), 64'd1);
            if (k == extra_at - 1) start = 1'b1;
            if (k == extra_at) start = 1'b0;
            if (k == rst_at - 1) restart = 1'b1;
            if (k == rst_at) begin
                restart = 1'b0;
                exp_score = 0;
                exp_score_s = 0;
                check_zero("abort");
            end
            if (done) begin
                dones++;
                if (done_k < 0) done_k = k;
                got_b = board_out;
                got_l = lines_cleared;
                got_s = score;
                got_ss = score_s;
            end
        end
        if (rst_at > 0) begin
            check("abort_dones", 64'(dones), 64'd0);
            check("abort_hold", 64'(board_out), 64'd0);
        end else begin
            exp_score = exp_score + n * n;
            if (exp_score > 65535) exp_score = 65535;
            exp_score_s = exp_score_s + n * n;
            if (exp_score_s > 63) exp_score_s = 63;
            check("dones", 64'(dones), 64'd1);
            check("done_at", 64'(done_k), 64'(ROWS + 1));
            check("board", 64'(got_b), 64'(exp_b));
            check("lines", 64'(got_l), 64'(n));
            check("score", 64'(got_s), 64'(exp_score));
            check("score_sat", 64'(got_ss), 64'(exp_score_s));
            check("board_hold", 64'(board_out), 64'(exp_b));
            check("idle_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic [W-1:0] rb;
        repeat (2) @(posedge clka);
        @(negedge clka);
        restart = 1'b0;
        check_zero("reset");

        run_board(32'h12345678, -1, -1);
        run_board(32'hF1000000, -1, -1);
        run_board(32'hF3F80000, -1, -1);
        run_board(32'hFFFFFFFF, -1, -1);
        run_board(32'hF0FFF3FF, 3, -1);
        run_board(32'hFFFF00FF, -1, 4);
        run_board(32'hF1000000, -1, -1);
        for (int i = 0; i < 24; i++) begin
            rb = $urandom;
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(0, 2) == 0) rb[r*COLS +: COLS] = '1;
            end
            run_board(rb, -1, -1);
        end
        run_board(32'hFFFFFFFF, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
